// File: rtl/fan_adder_2to2_node.sv
// Two-lane FAN reduction node: merges an adjacent pair of partial-sum lines
// when they target the same row and agree to merge, otherwise forwards both; registered output.
module fan_adder_2to2_node #(
    parameter int DW_DATA = 8,
    parameter int DW_ROW  = 4,
    parameter int DW_CTRL = 4,
    parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*DW_LINE-1:0] in,
    output logic [2*DW_LINE-1:0] out
);

    localparam int ROW_LSB  = DW_DATA;
    localparam int CTRL_LSB = DW_DATA + DW_ROW;

    logic [DW_LINE-1:0]   hi;
    logic [DW_LINE-1:0]   lo;
    logic [DW_DATA-1:0]   hi_data;
    logic [DW_DATA-1:0]   lo_data;
    logic [DW_ROW-1:0]    hi_row;
    logic [DW_ROW-1:0]    lo_row;
    logic [DW_CTRL-1:0]   hi_ctrl;
    logic [DW_CTRL-1:0]   lo_ctrl;
    logic                 add_en;
    logic [DW_DATA-1:0]   sum;
    logic [DW_CTRL-1:0]   merged_ctrl;
    logic [2*DW_LINE-1:0] out_next;

    always_comb begin
        hi      = in[2*DW_LINE-1:DW_LINE];
        lo      = in[DW_LINE-1:0];
        hi_data = hi[DW_DATA-1:0];
        lo_data = lo[DW_DATA-1:0];
        hi_row  = hi[CTRL_LSB-1:ROW_LSB];
        lo_row  = lo[CTRL_LSB-1:ROW_LSB];
        hi_ctrl = hi[DW_LINE-1:CTRL_LSB];
        lo_ctrl = lo[DW_LINE-1:CTRL_LSB];
    end

    // The merged line keeps the outermost merge flags so it can combine again at the next level.
    always_comb begin
        add_en      = hi_ctrl[3] & lo_ctrl[3] & hi_ctrl[1] & lo_ctrl[0] & (hi_row == lo_row);
        sum         = hi_data + lo_data;
        merged_ctrl = {1'b1, hi_ctrl[2] | lo_ctrl[2], lo_ctrl[1], hi_ctrl[0]};
        out_next    = in;
        if (add_en) begin
            out_next = {merged_ctrl, hi_row, sum, {DW_LINE{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_fan_adder_2to2_node.sv
// Bench for fan_adder_2to2_node: directed vector table, reset corner sequences,
// and randomized pairs checked against an arithmetic reference model.
module tb_fan_adder_2to2_node;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic [31:0] dout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] stim;
        logic [31:0] expect_out;
    } vec_t;

    vec_t vecs[$];

    fan_adder_2to2_node #(
        .DW_DATA(8),
        .DW_ROW (4),
        .DW_CTRL(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (din),
        .out  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decode fields arithmetically and apply the merge rule directly.
    function automatic logic [31:0] ref_node(input logic [31:0] pair);
        int hi, lo, hi_ctrl, lo_ctrl, hi_row, lo_row, hi_data, lo_data, res_ctrl, res;
        hi      = int'(pair) >>> 16 & 16'hFFFF;
        lo      = int'(pair) & 16'hFFFF;
        hi_ctrl = hi / 4096;
        lo_ctrl = lo / 4096;
        hi_row  = (hi / 256) % 16;
        lo_row  = (lo / 256) % 16;
        hi_data = hi % 256;
        lo_data = lo % 256;
        if ((hi_ctrl / 8) == 1 && (lo_ctrl / 8) == 1 && ((hi_ctrl / 2) % 2) == 1 &&
            (lo_ctrl % 2) == 1 && hi_row == lo_row) begin
            res_ctrl = 8;
            if (((hi_ctrl / 4) % 2) == 1 || ((lo_ctrl / 4) % 2) == 1) res_ctrl += 4;
            if (((lo_ctrl / 2) % 2) == 1) res_ctrl += 2;
            if ((hi_ctrl % 2) == 1) res_ctrl += 1;
            res = res_ctrl * 4096 + hi_row * 256 + (hi_data + lo_data) % 256;
            return logic'(1'b0) ? 32'h0 : {res[15:0], 16'h0000};
        end
        return pair;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] v);
        @(negedge clk);
        din = v;
    endtask

    function automatic logic [15:0] rand_line(input logic [3:0] row);
        logic [15:0] l;
        l = 16'($urandom);
        l[11:8] = row;
        return l;
    endfunction

    initial begin
        logic [31:0] stim;
        logic [31:0] prev_exp;
        logic [15:0] h, l;

        vecs.push_back('{"add_basic",      32'hA001_9002, 32'h8003_0000});
        vecs.push_back('{"lo_no_mergeup",  32'hA101_8102, 32'hA101_8102});
        vecs.push_back('{"lo_invalid",     32'hA101_7002, 32'hA101_7002});
        vecs.push_back('{"row_mismatch",   32'hA0FF_9101, 32'hA0FF_9101});
        vecs.push_back('{"row_mismatch2",  32'hE3FF_BF02, 32'hE3FF_BF02});
        vecs.push_back('{"wrap_inherit",   32'hE3FF_B302, 32'hE301_0000});
        vecs.push_back('{"hi_invalid",     32'h2303_B301, 32'h2303_B301});
        vecs.push_back('{"hi_no_mergedn",  32'h8303_B301, 32'h8303_B301});
        vecs.push_back('{"all_flags_add",  32'hF780_F780, 32'hF700_0000});

        rst_n = 1'b0;
        din   = 32'h0;
        #3;
        check_output("reset_async", dout, 32'h0);
        @(posedge clk);
        #1;
        check_output("reset_held", dout, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        din   = 32'hA001_9002;
        @(negedge clk);
        check_output("first_after_release", dout, 32'h8003_0000);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].stim);
            @(negedge clk);
            check_output(vecs[i].name, dout, vecs[i].expect_out);
            check_output({vecs[i].name, "_model"}, dout, ref_node(vecs[i].stim));
        end

        // Back-to-back: alternate merge-eligible and bypass pairs every cycle.
        prev_exp = 32'h0;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] row;
            row = 4'($urandom);
            h = rand_line(row);
            l = rand_line(row);
            if (i % 2 == 0) begin
                h[15] = 1'b1; h[13] = 1'b1;
                l[15] = 1'b1; l[12] = 1'b1;
            end else begin
                l[12] = 1'b0;
            end
            stim = {h, l};
            @(negedge clk);
            if (i > 0) check_output("back_to_back", dout, prev_exp);
            din      = stim;
            prev_exp = ref_node(stim);
        end
        @(negedge clk);
        check_output("back_to_back_last", dout, prev_exp);

        // Fully random pairs, half of them forced onto a shared row.
        for (int i = 0; i < 300; i++) begin
            h = 16'($urandom);
            l = 16'($urandom);
            if ($urandom_range(1, 0) == 1) l[11:8] = h[11:8];
            stim = {h, l};
            @(negedge clk);
            if (i > 0) check_output("random", dout, prev_exp);
            din      = stim;
            prev_exp = ref_node(stim);
        end
        @(negedge clk);
        check_output("random_last", dout, prev_exp);

        // Reset pulsed between edges discards the in-flight result.
        din = 32'hA001_9002;
        @(posedge clk);
        #2;
        check_output("pre_midreset", dout, 32'h8003_0000);
        rst_n = 1'b0;
        #1;
        check_output("midreset_async", dout, 32'h0);
        din = 32'hxxxx_xxxx;
        @(posedge clk);
        #1;
        check_output("midreset_x_blocked", dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        din   = 32'hE3FF_B302;
        #1;
        check_output("release_before_edge", dout, 32'h0);
        @(negedge clk);
        check_output("midreset_recover", dout, 32'hE301_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
